// File: rtl/oc_dut_pkg.sv
// Shared mode encodings and width helper for the overclocking-bench DUT pipeline.
package oc_dut_pkg;

    typedef enum logic [1:0] {
        MODE_CAT = 2'd0,
        MODE_ADD = 2'd1,
        MODE_MUL = 2'd2,
        MODE_XOR = 2'd3
    } mode_e;

    function automatic int unsigned res_width(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/oc_delay_line.sv
// Enable-gated shift register of Length stages; tail_d_o is the value about to load
// into the final stage, so callers can act on the same edge it lands.
module oc_delay_line #(
    parameter int unsigned Width  = 8,
    parameter int unsigned Length = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] tail_d_o,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage_q [Length];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Length; i++) begin
                stage_q[i] <= '0;
            end
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < Length; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    generate
        if (Length == 1) begin : g_single
            assign tail_d_o = d_i;
        end else begin : g_multi
            assign tail_d_o = stage_q[Length-2];
        end
    endgenerate

    assign q_o = stage_q[Length-1];

endmodule

// File: rtl/oc_dut_pipe.sv
// Pipelined capture/compute DUT with valid tracking and saturating result counter.
// Define OCB_PARITY_CHECK_EN to carry a parity bit and expose the sticky PAR_ERR output.
module oc_dut_pipe
    import oc_dut_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         EN,
    input  logic                         IN_VALID,
    input  logic [1:0]                   MODE,
    input  logic [WIDTH-1:0]             A,
    input  logic [WIDTH-1:0]             B,
    output logic [res_width(WIDTH)-1:0]  OUT,
    output logic                         OUT_VALID,
`ifdef OCB_PARITY_CHECK_EN
    output logic                         PAR_ERR,
`endif
    output logic [CNT_W-1:0]             OUT_CNT
);

    localparam int unsigned RW = res_width(WIDTH);
`ifdef OCB_PARITY_CHECK_EN
    localparam int unsigned BW = RW + 2;
`else
    localparam int unsigned BW = RW + 1;
`endif

    logic [WIDTH-1:0] a_q, b_q;
    mode_e            mode_q;
    logic             v1_q;
    logic [RW-1:0]    result;
    logic [BW-1:0]    bundle_d, bundle_tail, bundle_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= MODE_CAT;
            v1_q   <= 1'b0;
        end else if (EN) begin
            a_q    <= A;
            b_q    <= B;
            mode_q <= mode_e'(MODE);
            v1_q   <= IN_VALID;
        end
    end

    always_comb begin
        result = '0;
        unique case (mode_q)
            MODE_CAT: result = {b_q, a_q};
            MODE_ADD: result = RW'(a_q) + RW'(b_q);
            MODE_MUL: result = RW'(a_q) * RW'(b_q);
            MODE_XOR: result = RW'(a_q ^ b_q);
            default:  result = '0;
        endcase
    end

`ifdef OCB_PARITY_CHECK_EN
    assign bundle_d = {^result, v1_q, result};
`else
    assign bundle_d = {v1_q, result};
`endif

    oc_delay_line #(
        .Width  (BW),
        .Length (DEPTH - 1)
    ) u_delay (
        .clk_i    (CLK),
        .rst_i    (RST),
        .en_i     (EN),
        .d_i      (bundle_d),
        .tail_d_o (bundle_tail),
        .q_o      (bundle_q)
    );

    assign OUT       = bundle_q[RW-1:0];
    assign OUT_VALID = bundle_q[RW];

    // Count on the edge a valid result lands in the output stage; saturate at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (EN && bundle_tail[RW] && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign OUT_CNT = cnt_q;

`ifdef OCB_PARITY_CHECK_EN
    logic par_err_q, par_err_d;

    always_comb begin
        par_err_d = par_err_q;
        if (EN && OUT_VALID && ((^OUT) != bundle_q[RW+1])) begin
            par_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign PAR_ERR = par_err_q;
`endif

endmodule

// File: tb/tb_oc_dut_pipe.sv
// Scoreboard bench for oc_dut_pipe: stimulus queues expected results with their due
// enabled-edge index; a monitor checks OUT/OUT_VALID/OUT_CNT after every edge.
module tb_oc_dut_pipe;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              EN = 1'b0;
    logic              IN_VALID = 1'b0;
    logic [1:0]        MODE = 2'd0;
    logic [W-1:0]      A = '0;
    logic [W-1:0]      B = '0;
    logic [2*W-1:0]    OUT;
    logic              OUT_VALID;
    logic [CW-1:0]     OUT_CNT;
`ifdef OCB_PARITY_CHECK_EN
    logic              PAR_ERR;
`endif

    oc_dut_pipe #(
        .WIDTH (W),
        .DEPTH (D),
        .CNT_W (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .IN_VALID  (IN_VALID),
        .MODE      (MODE),
        .A         (A),
        .B         (B),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
`ifdef OCB_PARITY_CHECK_EN
        .PAR_ERR   (PAR_ERR),
`endif
        .OUT_CNT   (OUT_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned    due;
        logic [2*W-1:0] data;
    } exp_t;

    exp_t           sb_q[$];
    int unsigned    en_cnt    = 0;
    int unsigned    delivered = 0;
    logic           exp_valid = 1'b0;
    logic [2*W-1:0] exp_out   = '0;
    int             tests = 0;
    int             fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_calc(input logic [1:0] m, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [2*W-1:0] ea, eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        case (m)
            2'd0:    return {b, a};
            2'd1:    return ea + eb;
            2'd2:    return ea * eb;
            default: return ea ^ eb;
        endcase
    endfunction

    // Inputs change on the falling edge; a captured valid sample is due D enabled edges on.
    task automatic drive(input logic en, input logic v, input logic [1:0] m,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp);
        exp_t e;
        @(negedge CLK);
        EN = en;
        IN_VALID = v;
        MODE = m;
        A = a;
        B = b;
        if (en && v) begin
            e.due  = en_cnt + D;
            e.data = exp;
            sb_q.push_back(e);
        end
    endtask

    task automatic drive_rand(input logic en, input logic v);
        logic [1:0]   m;
        logic [W-1:0] a, b;
        m = 2'($urandom_range(0, 3));
        a = W'($urandom);
        b = W'($urandom);
        drive(en, v, m, a, b, ref_calc(m, a, b));
    endtask

    task automatic do_reset(input logic check_zero);
        @(negedge CLK);
        RST = 1'b1;
        EN = 1'b0;
        IN_VALID = 1'b0;
        #1;
        if (check_zero) begin
            check("rst_out", 64'(OUT), 64'd0);
            check("rst_out_valid", 64'(OUT_VALID), 64'd0);
            check("rst_out_cnt", 64'(OUT_CNT), 64'd0);
        end
        sb_q.delete();
        delivered = 0;
        exp_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Monitor: reference behaviour per edge, counted in enabled edges only.
    initial begin
        logic        en_s, rst_s;
        int unsigned exp_cnt;
        forever begin
            @(posedge CLK);
            en_s  = EN;
            rst_s = RST;
            #1;
            if (rst_s === 1'b0) begin
                if (en_s) begin
                    en_cnt++;
                    if (sb_q.size() > 0 && sb_q[0].due == en_cnt) begin
                        exp_valid = 1'b1;
                        exp_out   = sb_q[0].data;
                        void'(sb_q.pop_front());
                        delivered++;
                    end else begin
                        exp_valid = 1'b0;
                    end
                end
                check("out_valid", 64'(OUT_VALID), 64'(exp_valid));
                if (exp_valid) check("out_data", 64'(OUT), 64'(exp_out));
                exp_cnt = (delivered > CNT_MAX) ? CNT_MAX : delivered;
                check("out_cnt", 64'(OUT_CNT), 64'(exp_cnt));
`ifdef OCB_PARITY_CHECK_EN
                check("par_err", 64'(PAR_ERR), 64'd0);
`endif
            end
        end
    end

    initial begin
        do_reset(1'b0);
        check("init_out_valid", 64'(OUT_VALID), 64'd0);
        check("init_out_cnt", 64'(OUT_CNT), 64'd0);

        // Directed vectors, back to back.
        drive(1'b1, 1'b1, 2'd0, 16'h1234, 16'hABCD, 32'hABCD1234);
        drive(1'b1, 1'b1, 2'd1, 16'hFFFF, 16'h0001, 32'h00010000);
        drive(1'b1, 1'b1, 2'd2, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        drive(1'b1, 1'b1, 2'd3, 16'h00FF, 16'h0F0F, 32'h00000FF0);
        for (int i = 0; i < D + 1; i++) drive_rand(1'b1, 1'b0);

        // Stall after one edge; inputs presented while stalled must be ignored.
        drive_rand(1'b1, 1'b1);
        drive_rand(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive_rand(1'b0, 1'b1);
        for (int i = 0; i < D + 1; i++) drive_rand(1'b1, 1'b0);

        // Reset with two results in flight.
        drive_rand(1'b1, 1'b1);
        drive_rand(1'b1, 1'b1);
        do_reset(1'b1);
        for (int i = 0; i < D + 2; i++) drive_rand(1'b1, 1'b0);

        // Random traffic with stalls; also drives the counter into saturation.
        for (int i = 0; i < 400; i++) begin
            drive_rand(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7));
        end

        // Drain with a bounded number of enabled bubble cycles.
        for (int i = 0; i < D + 3; i++) drive_rand(1'b1, 1'b0);
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        check("cnt_saturated", 64'(OUT_CNT), 64'(CNT_MAX));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
